// File: rtl/fp_addsub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp_addsub_ctrl_pkg
// Shared definitions for the floating-point add/sub control block:
//   - state_t : controller state encoding
//   - op_t    : operation codes presented on the op port
//   - SHIFT_MAX_DEF / NORM_MAX_DEF : default parameter values
// ---------------------------------------------------------------------------
package fp_addsub_ctrl_pkg;

    localparam int SHIFT_MAX_DEF = 26;
    localparam int NORM_MAX_DEF  = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ALIGN     = 3'd1,
        COMPUTE   = 3'd2,
        NORMALIZE = 3'd3,
        ROUND     = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        ILL = 2'b11
    } op_t;

endpackage

// File: rtl/fp_align_calc.sv
// ---------------------------------------------------------------------------
// fp_align_calc
// Combinational exponent compare and alignment-shift saturation.
// Ports:
//   exp_a, exp_b  : biased operand exponents
//   bypass        : force a zero shift (multiply needs no alignment)
//   smaller_src   : 1 when exp_a >= exp_b (B is the smaller operand), else 0
//   shift_qtt     : min(|exp_a - exp_b|, SHIFT_MAX), or 0 when bypassed
// ---------------------------------------------------------------------------
module fp_align_calc
    import fp_addsub_ctrl_pkg::*;
#(
    parameter int SHIFT_MAX = SHIFT_MAX_DEF
) (
    input  logic [7:0] exp_a,
    input  logic [7:0] exp_b,
    input  logic       bypass,
    output logic       smaller_src,
    output logic [7:0] shift_qtt
);

    logic [8:0] diff_ab;
    logic [8:0] diff_ba;
    logic [8:0] mag;

    // Both 9-bit differences are formed; the borrow bit of a-b tells which
    // operand is smaller and selects the non-negative one as the magnitude.
    always_comb begin
        diff_ab     = {1'b0, exp_a} - {1'b0, exp_b};
        diff_ba     = {1'b0, exp_b} - {1'b0, exp_a};
        smaller_src = ~diff_ab[8];
        mag         = diff_ab[8] ? diff_ba : diff_ab;
        if (bypass) begin
            shift_qtt = '0;
        end else if (mag > 9'(SHIFT_MAX)) begin
            shift_qtt = 8'(SHIFT_MAX);
        end else begin
            shift_qtt = mag[7:0];
        end
    end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// fp_addsub_ctrl
// Sequencing controller for a floating-point add/sub datapath:
// IDLE -> ALIGN -> COMPUTE -> NORMALIZE (steps) -> ROUND -> DONE.
// Optional feature macro: FP_CTRL_MUL_EN -- when defined, op=10 (multiply)
// runs the add/sub flow with a zero alignment shift; otherwise op=10 is
// rejected exactly like op=11.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, op           : request and operation code (sampled in IDLE only)
//   exp_a, exp_b        : operand exponents
//   alu_carry, frac_msb, frac_zero, round_ovf : datapath status inputs
//   smaller_exp_src, shift_right_qtt          : alignment controls
//   operation           : latched op for the big ALU
//   normalization_src   : 0 ALU result, 1 rounded result
//   shift_src, norm_step: normalization shift direction / enable
//   busy, done, zero, err : status
// ---------------------------------------------------------------------------
module fp_addsub_ctrl
    import fp_addsub_ctrl_pkg::*;
#(
    parameter int SHIFT_MAX = SHIFT_MAX_DEF,
    parameter int NORM_MAX  = NORM_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] exp_a,
    input  logic [7:0] exp_b,
    input  logic       alu_carry,
    input  logic       frac_msb,
    input  logic       frac_zero,
    input  logic       round_ovf,
    output logic       smaller_exp_src,
    output logic [7:0] shift_right_qtt,
    output logic [1:0] operation,
    output logic       normalization_src,
    output logic       shift_src,
    output logic       norm_step,
    output logic       busy,
    output logic       done,
    output logic       zero,
    output logic       err
);

`ifdef FP_CTRL_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    localparam int              CNT_W    = $clog2(NORM_MAX + 1);
    localparam logic [CNT_W-1:0] NORM_LIM = CNT_W'(NORM_MAX);

    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic             first_norm;
    logic             round_used;

    logic             req_illegal;
    logic             req_mul;
    logic             calc_smaller;
    logic [7:0]       calc_qtt;

    logic             right_step;
    logic             left_step;

    // Decode the incoming request; multiply is only legal when the feature
    // is built in, and a legal multiply skips alignment.
    always_comb begin
        req_mul     = (op == MUL);
        req_illegal = (op == ILL) || (req_mul && !MUL_EN);
    end

    fp_align_calc #(
        .SHIFT_MAX (SHIFT_MAX)
    ) u_align (
        .exp_a       (exp_a),
        .exp_b       (exp_b),
        .bypass      (req_mul && MUL_EN),
        .smaller_src (calc_smaller),
        .shift_qtt   (calc_qtt)
    );

    // Normalization decisions follow the datapath status in the same cycle,
    // so the shift enable and direction are decoded from state + inputs.
    // frac_zero has top priority; the right shift for an ALU carry is only
    // honoured in the first NORMALIZE cycle after COMPUTE.
    always_comb begin
        right_step = 1'b0;
        left_step  = 1'b0;
        if (state == NORMALIZE && !frac_zero) begin
            if (alu_carry && first_norm) begin
                right_step = 1'b1;
            end else if (!frac_msb && (step_cnt < NORM_LIM)) begin
                left_step = 1'b1;
            end
        end
        norm_step = right_step | left_step;
        shift_src = right_step;
    end

    // Main controller. Alignment results are captured at the accepting edge
    // so they are stable throughout ALIGN. DONE emits its one-cycle pulse:
    // paths arriving from ROUND/NORMALIZE raise done on entry, while a
    // rejected op enters DONE with done low and raises it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            step_cnt          <= '0;
            first_norm        <= 1'b0;
            round_used        <= 1'b0;
            smaller_exp_src   <= 1'b0;
            shift_right_qtt   <= '0;
            operation         <= 2'b00;
            normalization_src <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            zero              <= 1'b0;
            err               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        operation         <= op;
                        zero              <= 1'b0;
                        normalization_src <= 1'b0;
                        round_used        <= 1'b0;
                        busy              <= 1'b1;
                        if (req_illegal) begin
                            err             <= 1'b1;
                            smaller_exp_src <= 1'b0;
                            shift_right_qtt <= '0;
                            state           <= DONE;
                        end else begin
                            err             <= 1'b0;
                            smaller_exp_src <= calc_smaller;
                            shift_right_qtt <= calc_qtt;
                            state           <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    step_cnt   <= '0;
                    first_norm <= 1'b1;
                    state      <= NORMALIZE;
                end
                NORMALIZE: begin
                    first_norm <= 1'b0;
                    if (frac_zero) begin
                        zero  <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (left_step) begin
                        step_cnt <= step_cnt + 1'b1;
                    end else if (!right_step) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (round_ovf && !round_used) begin
                        round_used        <= 1'b1;
                        normalization_src <= 1'b1;
                        step_cnt          <= '0;
                        state             <= NORMALIZE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_addsub_ctrl.md
FP_ADDSUB_CTRL -- requirements
Module: fp_addsub_ctrl

Interface
- REQ-001 The block SHALL have parameter SHIFT_MAX, default 26, which is the alignment shift saturation limit and equals the fraction shifter width.
- REQ-002 The block SHALL have parameter NORM_MAX, default 24, which caps the number of left-normalization steps per operation.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
- REQ-006 The block SHALL have port op, input, 2 bits: 00 add, 01 sub, 10 mul, 11 illegal.
- REQ-007 The block SHALL have ports exp_a and exp_b, input, 8 bits each: biased exponents of the operands.
- REQ-008 The block SHALL have port alu_carry, input, 1 bit: big-ALU carry out.
- REQ-009 The block SHALL have port frac_msb, input, 1 bit: the hidden-bit position of the normalization input is 1.
- REQ-010 The block SHALL have port frac_zero, input, 1 bit: the fraction under normalization is all zero.
- REQ-011 The block SHALL have port round_ovf, input, 1 bit: rounding produced a fraction overflow.
- REQ-012 The block SHALL have port smaller_exp_src, output, 1 bit: 0 means A is smaller, 1 means B is smaller.
- REQ-013 The block SHALL have port shift_right_qtt, output, 8 bits: alignment shift amount.
- REQ-014 The block SHALL have port operation, output, 2 bits: the latched op, driven to the big ALU.
- REQ-015 The block SHALL have port normalization_src, output, 1 bit: 0 selects the ALU result, 1 selects the rounded result.
- REQ-016 The block SHALL have port shift_src, output, 1 bit: 0 left, 1 right.
- REQ-017 The block SHALL have port norm_step, output, 1 bit: perform one normalization shift this cycle.
- REQ-018 The block SHALL have ports busy, done, zero and err, output, 1 bit each: status.

Function
- REQ-019 The FSM states SHALL be IDLE, ALIGN, COMPUTE, NORMALIZE, ROUND and DONE.
- REQ-020 In IDLE, start=1 SHALL latch op, exp_a and exp_b and move to ALIGN; busy SHALL be 1 in every state except IDLE.
- REQ-021 ALIGN SHALL take one cycle: smaller_exp_src=1 when exp_a>=exp_b, else 0; shift_right_qtt=min(|exp_a-exp_b|, SHIFT_MAX), using 9-bit difference arithmetic.
- REQ-022 COMPUTE SHALL take one cycle with operation valid, then move to NORMALIZE with the step counter cleared.
- REQ-023 In NORMALIZE, evaluated in priority order each cycle:
  - frac_zero: zero=1, go to DONE.
  - alu_carry, first NORMALIZE cycle only: norm_step=1, shift_src=1, stay.
  - !frac_msb and counter<NORM_MAX: norm_step=1, shift_src=0, counter+1, stay.
  - otherwise: go to ROUND.
- REQ-024 ROUND SHALL take one cycle: round_ovf=1 sets normalization_src=1, clears the counter and returns to NORMALIZE, at most once per operation; otherwise go to DONE.
- REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; zero and err SHALL hold until the next accepted start.
- REQ-026 With no normalization steps, done SHALL rise 5 cycles after the start cycle; each norm_step cycle SHALL add 1 cycle.
- REQ-027 op=11 SHALL go IDLE -> DONE with err=1, and norm_step SHALL never assert for it.
- REQ-028 normalization_src SHALL be 0 from ALIGN until a round overflow occurs.
- REQ-029 start asserted while busy SHALL be ignored.

Reset
- REQ-030 rst=1 at any cycle, including mid-operation, SHALL force IDLE on the next edge and drive all outputs to 0 (shift_right_qtt=0, operation=00); a pending operation SHALL be discarded with no done.

Configuration
- REQ-031 With FP_CTRL_MUL_EN defined, op=10 SHALL follow the add/sub flow with shift_right_qtt=0 in ALIGN.
- REQ-032 Without FP_CTRL_MUL_EN, op=10 SHALL be treated as illegal, exactly as REQ-027.

Structure
- REQ-033 A shared package SHALL hold the state encoding enum, the op codes (ADD, SUB, MUL, ILL) and the SHIFT_MAX/NORM_MAX defaults.
- REQ-034 The exponent compare/saturate logic SHALL be one sub-module, fp_align_calc, which is combinational.

Verification
- REQ-035 exp_a=0x82, exp_b=0x80, op=00, no steps -> smaller_exp_src=1, shift_right_qtt=2, done 5 cycles after start.
- REQ-036 exp_a=0x10, exp_b=0xF0 -> smaller_exp_src=0, shift_right_qtt=26 (saturated).
- REQ-037 alu_carry=1 in the first NORMALIZE cycle -> exactly one norm_step with shift_src=1, done at cycle 6.
- REQ-038 frac_msb=0 for 3 NORMALIZE cycles -> 3 left steps, done at cycle 8; round_ovf=1 once -> normalization_src=1 and one extra NORMALIZE pass.
- REQ-039 rst during NORMALIZE -> IDLE next cycle, all outputs 0, no done pulse.
- REQ-040 op=10 without FP_CTRL_MUL_EN -> err=1, done 2 cycles after start; op=11 -> same response.
